sync_word_detector: RTL and testbench
=====================================

SYNC_WORD_DETECTOR -- requirements
Module: sync_word_detector

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width; even, >= 4.
REQ-002 SHALL have parameter PATTERN, default 32'habadface, meaning DW-bit sync word; PATTERN[DW-1:DW/2] is HI_MARK and PATTERN[DW/2-1:0] is LO_MARK.
REQ-003 SHALL have parameter FRAME_LEN, default 8, meaning valid words per frame including the sync word; >= 2.
REQ-004 SHALL have parameter LOCK_N, default 3, meaning consecutive in-slot sync words needed to lock; >= 1.
REQ-005 SHALL have parameter MISS_N, default 2, meaning consecutive in-slot misses that drop lock; >= 1.
REQ-006 SHALL have port sys_clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; always accepted, no backpressure.
REQ-009 SHALL have port in_data, input, DW bits: the input word.
REQ-010 SHALL have port resync, input, 1 bit: synchronous force to HUNT.
REQ-011 SHALL have port out_valid, output, 1 bit: registered copy of in_valid.
REQ-012 SHALL have port out_data, output, DW bits: registered copy of in_data.
REQ-013 SHALL have port out_code, output, 2 bits: registered classification of the word.
REQ-014 SHALL have port out_sof, output, 1 bit: the output word is the frame-start slot while locked.
REQ-015 SHALL have port locked, output, 1 bit: the FSM is in LOCKED.
REQ-016 SHALL have port lock_lost, output, 1 bit: one-cycle pulse on the LOCKED-to-HUNT transition caused by misses.

Function
REQ-017 SHALL classify each word by priority: 00 if word==PATTERN; else 01 if either half==HI_MARK; else 10 if either half==LO_MARK; else 11.
REQ-018 SHALL present out_valid, out_data, out_code and out_sof exactly 1 cycle after the input word; out_data and out_code hold when in_valid=0.
REQ-019 SHALL keep a position counter pos (0..FRAME_LEN-1) that advances only on valid words and wraps FRAME_LEN-1 -> 0; a "slot" is a valid word arriving with pos==0.
REQ-020 SHALL implement FSM states HUNT, CHECK and LOCKED with counters hits and misses; transitions occur only on valid words.
REQ-021 HUNT: a code-00 word SHALL set pos=1 and hits=1 and go to CHECK, or go directly to LOCKED when LOCK_N==1; other words SHALL leave the state and pos unchanged.
REQ-022 CHECK: a code-00 slot SHALL increment hits and go to LOCKED with misses=0 when hits reaches LOCK_N; a non-00 slot SHALL go to HUNT with hits=0; non-slot words, including sync words, SHALL be ignored by the FSM.
REQ-023 LOCKED: a code-00 slot SHALL clear misses; a non-00 slot SHALL increment misses and, on reaching MISS_N, go to HUNT, clear hits and misses, and pulse lock_lost; off-slot sync words SHALL be ignored.
REQ-024 SHALL drive out_sof=1 for every slot word accepted while in LOCKED (flywheel behaviour, regardless of out_code), and 0 otherwise.
REQ-025 SHALL drive locked from the registered state, changing on the same edge as the transition.
REQ-026 resync=1 SHALL force HUNT and clear pos, hits and misses, with priority over any FSM action that cycle; the word is still classified and output, and lock_lost SHALL NOT pulse.
REQ-027 SHALL size counters with $clog2 of their limit, and no counter SHALL overflow or wrap except pos.

Reset
REQ-028 sys_rst_n=0 SHALL immediately set state HUNT, clear pos, hits and misses, and drive out_valid, out_data, out_code, out_sof, locked and lock_lost to 0, without waiting for a clock edge.
REQ-029 Deasserting reset SHALL need no warm-up cycles; the first valid word after deassertion SHALL be processed normally.

Verification (DW=32, PATTERN=abadface, FRAME_LEN=8, LOCK_N=3, MISS_N=2; word n = nth valid word)
REQ-030 Classify: words abadface, 0000abad, face1234, faceabad, 12345678 back-to-back -> out_code 00, 01, 10, 01, 11, each one cycle later.
REQ-031 Acquire: sync at n=0, 8 and 16 with 0 elsewhere, plus idle gaps -> locked rises the edge after n=16; out_sof=1 on the output of n=24, 32, ...
REQ-032 Tolerate and drop: locked, junk at n=24 and sync at n=32 -> stays locked; then junk at n=40 and 48 -> lock_lost pulses once with n=48's output and locked falls.
REQ-033 CHECK fail: sync at n=0, sync at n=5 (ignored), junk at n=8 -> HUNT, locked never rises; a sync at n=9 restarts CHECK with n=9 as the new slot.
REQ-034 resync while locked -> locked=0 next edge, no lock_lost pulse; asserting sys_rst_n=0 mid-frame -> all outputs 0 asynchronously; reacquisition then takes the full LOCK_N frames.

Source files
------------

// File: rtl/sync_word_detector.sv
// Sync-word framer: classifies each input word against a sync pattern and
// tracks frame alignment with a HUNT/CHECK/LOCKED flywheel.
module sync_word_detector #(
    parameter int unsigned     DW        = 32,
    parameter logic [DW-1:0]   PATTERN   = 32'habadface,
    parameter int unsigned     FRAME_LEN = 8,
    parameter int unsigned     LOCK_N    = 3,
    parameter int unsigned     MISS_N    = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          resync,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_code,
    output logic          out_sof,
    output logic          locked,
    output logic          lock_lost
);

    localparam int unsigned HW  = DW / 2;
    localparam int unsigned PW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned HCW = $clog2(LOCK_N + 1);
    localparam int unsigned MCW = $clog2(MISS_N + 1);

    localparam logic [HW-1:0] HI_MARK = PATTERN[DW-1:HW];
    localparam logic [HW-1:0] LO_MARK = PATTERN[HW-1:0];

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_e;

    state_e         state_q;
    logic [PW-1:0]  pos_q;
    logic [HCW-1:0] hits_q;
    logic [MCW-1:0] misses_q;

    logic [1:0]     code_d;
    logic           slot_d;
    logic [PW-1:0]  pos_d;
    logic [HW-1:0]  hi_d;
    logic [HW-1:0]  lo_d;

    always_comb begin
        hi_d   = in_data[DW-1:HW];
        lo_d   = in_data[HW-1:0];
        code_d = 2'b11;
        if (in_data == PATTERN) begin
            code_d = 2'b00;
        end else if ((hi_d == HI_MARK) || (lo_d == HI_MARK)) begin
            code_d = 2'b01;
        end else if ((hi_d == LO_MARK) || (lo_d == LO_MARK)) begin
            code_d = 2'b10;
        end
    end

    always_comb begin
        slot_d = (pos_q == '0);
        if (pos_q == PW'(FRAME_LEN - 1)) begin
            pos_d = '0;
        end else begin
            pos_d = pos_q + 1'b1;
        end
    end

    assign locked = (state_q == LOCKED);

    // resync overrides every FSM action but never touches the output datapath.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= HUNT;
            pos_q     <= '0;
            hits_q    <= '0;
            misses_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_code  <= '0;
            out_sof   <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_sof   <= 1'b0;
            lock_lost <= 1'b0;
            if (in_valid) begin
                out_data <= in_data;
                out_code <= code_d;
                out_sof  <= slot_d && (state_q == LOCKED);
            end

            if (resync) begin
                state_q  <= HUNT;
                pos_q    <= '0;
                hits_q   <= '0;
                misses_q <= '0;
            end else if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (code_d == 2'b00) begin
                            pos_q  <= PW'(1);
                            hits_q <= HCW'(1);
                            if (LOCK_N == 1) begin
                                state_q  <= LOCKED;
                                misses_q <= '0;
                            end else begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        pos_q <= pos_d;
                        if (slot_d) begin
                            if (code_d == 2'b00) begin
                                hits_q <= hits_q + 1'b1;
                                if (hits_q == HCW'(LOCK_N - 1)) begin
                                    state_q  <= LOCKED;
                                    misses_q <= '0;
                                end
                            end else begin
                                state_q <= HUNT;
                                hits_q  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        pos_q <= pos_d;
                        if (slot_d) begin
                            if (code_d == 2'b00) begin
                                misses_q <= '0;
                            end else if (misses_q == MCW'(MISS_N - 1)) begin
                                state_q   <= HUNT;
                                hits_q    <= '0;
                                misses_q  <= '0;
                                lock_lost <= 1'b1;
                            end else begin
                                misses_q <= misses_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_word_detector.sv
// Bench for sync_word_detector: directed frame scenarios with literal
// expectations plus a randomized framed stream, all checked against a model.
module tb_sync_word_detector;

    localparam int unsigned DW        = 32;
    localparam logic [31:0] PAT       = 32'habadface;
    localparam logic [15:0] MARK_HI   = 16'habad;
    localparam logic [15:0] MARK_LO   = 16'hface;
    localparam int          FLEN      = 8;
    localparam int          LOCKN     = 3;
    localparam int          MISSN     = 2;
    localparam logic [31:0] JUNK      = 32'hdeadbeef;

    localparam int S_HUNT  = 0;
    localparam int S_CHECK = 1;
    localparam int S_LOCK  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          resync = 1'b0;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [1:0]    out_code;
    logic          out_sof;
    logic          locked;
    logic          lock_lost;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    sync_word_detector #(
        .DW        (DW),
        .PATTERN   (PAT),
        .FRAME_LEN (FLEN),
        .LOCK_N    (LOCKN),
        .MISS_N    (MISSN)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .resync    (resync),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_code  (out_code),
        .out_sof   (out_sof),
        .locked    (locked),
        .lock_lost (lock_lost)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [1:0] classify(input logic [31:0] w);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = w[31:16];
        lo = w[15:0];
        if (w == PAT) return 2'd0;
        if (hi == MARK_HI || lo == MARK_HI) return 2'd1;
        if (hi == MARK_LO || lo == MARK_LO) return 2'd2;
        return 2'd3;
    endfunction

    // Behavioural model: frame position, hit/miss tallies, expected outputs.
    int          m_st = S_HUNT;
    int          m_pos = 0;
    int          m_hits = 0;
    int          m_miss = 0;
    logic        e_valid = 1'b0;
    logic [31:0] e_data = '0;
    logic [1:0]  e_code = '0;
    logic        e_sof = 1'b0;
    logic        e_lost = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_st = S_HUNT; m_pos = 0; m_hits = 0; m_miss = 0;
            e_valid = 0; e_data = '0; e_code = '0; e_sof = 0; e_lost = 0;
        end else begin
            logic [1:0] c;
            bit slot;
            c = classify(in_data);
            slot = (m_pos == 0);
            e_valid = in_valid;
            e_lost = 0;
            e_sof = in_valid && slot && (m_st == S_LOCK);
            if (in_valid) begin
                e_data = in_data;
                e_code = c;
            end
            if (resync) begin
                m_st = S_HUNT; m_pos = 0; m_hits = 0; m_miss = 0;
            end else if (in_valid) begin
                if (m_st == S_HUNT) begin
                    if (c == 0) begin
                        m_pos = 1; m_hits = 1;
                        if (m_hits >= LOCKN) begin m_st = S_LOCK; m_miss = 0; end
                        else m_st = S_CHECK;
                    end
                end else begin
                    m_pos = (m_pos + 1) % FLEN;
                    if (slot && m_st == S_CHECK) begin
                        if (c == 0) begin
                            m_hits++;
                            if (m_hits == LOCKN) begin m_st = S_LOCK; m_miss = 0; end
                        end else begin
                            m_st = S_HUNT; m_hits = 0;
                        end
                    end else if (slot) begin
                        if (c == 0) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss == MISSN) begin
                                m_st = S_HUNT; m_hits = 0; m_miss = 0; e_lost = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_data",  out_data, e_data);
            chk("out_code",  32'(out_code), 32'(e_code));
            chk("out_sof",   32'(out_sof), 32'(e_sof));
            chk("locked",    32'(locked), 32'(m_st == S_LOCK));
            chk("lock_lost", 32'(lock_lost), 32'(e_lost));
        end
    end

    task automatic send(input logic v, input logic [31:0] d, input logic rs);
        in_valid = v;
        in_data  = d;
        resync   = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic word(input logic [31:0] d);
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) send(1'b0, r, 1'b0);
        send(1'b1, d, 1'b0);
    endtask

    task automatic fillers(input int n);
        for (int i = 0; i < n; i++) word(32'h0);
    endtask

    task automatic zeros_check(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_data"},  out_data, 32'h0);
        chk({tag, "_code"},  32'(out_code), 32'h0);
        chk({tag, "_sof"},   32'(out_sof), 32'h0);
        chk({tag, "_locked"}, 32'(locked), 32'h0);
        chk({tag, "_lost"},  32'(lock_lost), 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] d;
        int k;

        repeat (3) @(posedge clk);
        #2;
        zeros_check("reset");
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Classification, back-to-back
        send(1, 32'habadface, 0); chk("cls0", 32'(out_code), 32'd0);
        chk("cls0_data", out_data, 32'habadface);
        send(1, 32'h0000abad, 0); chk("cls1", 32'(out_code), 32'd1);
        send(1, 32'hface1234, 0); chk("cls2", 32'(out_code), 32'd2);
        send(1, 32'hfaceabad, 0); chk("cls3", 32'(out_code), 32'd1);
        send(1, 32'h12345678, 0); chk("cls4", 32'(out_code), 32'd3);
        send(0, 32'h11111111, 0);
        chk("hold_valid", 32'(out_valid), 32'h0);
        chk("hold_data", out_data, 32'h12345678);
        chk("hold_code", 32'(out_code), 32'd3);
        send(0, 32'h0, 1);

        // Acquire, tolerate one miss, then drop on two
        word(PAT); fillers(7);
        word(PAT); chk("acq_n8_locked", 32'(locked), 32'h0); fillers(7);
        word(PAT); chk("acq_n16_locked", 32'(locked), 32'h1);
        chk("acq_n16_sof", 32'(out_sof), 32'h0); fillers(7);
        word(JUNK); chk("n24_locked", 32'(locked), 32'h1);
        chk("n24_sof", 32'(out_sof), 32'h1); chk("n24_lost", 32'(lock_lost), 32'h0); fillers(7);
        word(PAT); chk("n32_sof", 32'(out_sof), 32'h1); fillers(7);
        word(JUNK); chk("n40_lost", 32'(lock_lost), 32'h0); fillers(7);
        word(JUNK); chk("n48_lost", 32'(lock_lost), 32'h1);
        chk("n48_locked", 32'(locked), 32'h0); chk("n48_sof", 32'(out_sof), 32'h1);
        word(32'h0); chk("n49_lost", 32'(lock_lost), 32'h0);

        // CHECK failure and restart
        send(0, 32'h0, 1);
        word(PAT); fillers(4); word(PAT); fillers(2);
        word(JUNK); chk("chkfail_locked", 32'(locked), 32'h0);
        word(PAT); fillers(7);
        word(PAT); chk("restart_n17", 32'(locked), 32'h0); fillers(7);
        word(PAT); chk("restart_n25", 32'(locked), 32'h1);

        // resync while locked
        send(1, 32'h0, 1);
        chk("resync_locked", 32'(locked), 32'h0);
        chk("resync_lost", 32'(lock_lost), 32'h0);
        chk("resync_valid", 32'(out_valid), 32'h1);

        // Async reset mid-frame, then full reacquisition
        word(PAT); fillers(7); word(PAT); fillers(7); word(PAT); fillers(3);
        chk("pre_rst_locked", 32'(locked), 32'h1);
        in_valid = 1'b1; in_data = PAT;
        rst_n = 1'b0;
        #1;
        zeros_check("async_rst");
        @(posedge clk); #2;
        send(0, 32'h0, 0);
        rst_n = 1'b1;
        word(PAT); fillers(7);
        word(PAT); chk("reacq_n8", 32'(locked), 32'h0); fillers(7);
        word(PAT); chk("reacq_n16", 32'(locked), 32'h1);

        // Randomized framed stream with slips, stray syncs and rare resyncs
        k = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                send(1'b0, r, ($urandom_range(0, 199) == 0));
            end else begin
                if (k == 0) d = ($urandom_range(0, 99) < 85) ? PAT : r;
                else begin
                    case ($urandom_range(0, 9))
                        0: d = PAT;
                        1: d = {MARK_HI, r[15:0]};
                        2: d = {r[31:16], MARK_LO};
                        default: d = r;
                    endcase
                end
                send(1'b1, d, ($urandom_range(0, 199) == 0));
                if ($urandom_range(0, 49) != 0) k = (k + 1) % FLEN;
            end
        end

        send(0, 32'h0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
